// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine plus per-cycle arbiter for one shared single-port memory bus (DMA > PPU > CPU).
// Bus outputs are combinational from registered state; read data comes back through registered rdata ports.
module oam_dma_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic [1:0]  ppu_mode,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;
  typedef enum logic [1:0] {G_NONE, G_CPU, G_PPU} grant_t;

  state_t     state;
  grant_t     grant_q;
  logic [7:0] src;
  logic [7:0] idx;

  logic trigger, dma_bus, last_byte, abort_wr;
  logic in_hram, in_vram, in_oam, cpu_blocked;
  logic ppu_grant, cpu_grant;

  assign trigger   = cpu_wr && (cpu_addr == 16'hFF46);
  assign dma_bus   = (state == READ) || (state == WRITE);
  assign last_byte = (idx == 8'd159);
  // A retrigger mid-transfer discards the byte in flight, except the final one.
  assign abort_wr  = trigger && (state == WRITE) && !last_byte;

  assign in_hram = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign in_vram = (cpu_addr >= 16'h8000) && (cpu_addr <= 16'h9FFF);
  assign in_oam  = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);

  assign cpu_blocked = (dma_active && !in_hram && (cpu_addr != 16'hFF46))
                    || (in_vram && (ppu_mode == 2'd3))
                    || (in_oam && ppu_mode[1]);

  assign ppu_grant = ppu_rd && !dma_bus && !rst;
  assign cpu_grant = (cpu_rd || cpu_wr) && !cpu_blocked && !dma_bus && !ppu_rd && !rst;

  always_comb begin
    mem_addr  = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    if (!rst) begin
      if (state == READ) begin
        mem_addr = {src, idx};
        mem_rd   = 1'b1;
      end else if (state == WRITE) begin
        if (!abort_wr) begin
          mem_addr  = {8'hFE, idx};
          mem_wr    = 1'b1;
          mem_wdata = mem_rdata;
        end
      end else if (ppu_grant) begin
        mem_addr = ppu_addr;
        mem_rd   = 1'b1;
      end else if (cpu_grant) begin
        mem_addr  = cpu_addr;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_wdata = cpu_wr ? cpu_wdata : 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src        <= 8'h00;
      idx        <= 8'h00;
      dma_active <= 1'b0;
      grant_q    <= G_NONE;
      cpu_rdata  <= 8'hFF;
      ppu_rdata  <= 8'hFF;
    end else begin
      if (ppu_grant)
        grant_q <= G_PPU;
      else if (cpu_grant && cpu_rd)
        grant_q <= G_CPU;
      else
        grant_q <= G_NONE;
      // mem_rdata is valid in the cycle after the granted read; capture it then.
      cpu_rdata <= (grant_q == G_CPU) ? mem_rdata : 8'hFF;
      ppu_rdata <= (grant_q == G_PPU) ? mem_rdata : 8'hFF;

      if (trigger) begin
        src        <= (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
        idx        <= 8'h00;
        state      <= START;
        dma_active <= 1'b1;
      end else begin
        case (state)
          START: state <= READ;
          READ:  state <= WRITE;
          WRITE: begin
            if (last_byte) begin
              state      <= IDLE;
              dma_active <= 1'b0;
            end else begin
              idx   <= idx + 8'd1;
              state <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: behavioural memory, read scoreboard, OAM content and timing checks.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic [1:0]  ppu_mode = 2'd1;
  logic        ppu_rd = 1'b0;
  logic [15:0] ppu_addr = 16'h0000;
  logic [7:0]  ppu_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        dma_active;

  oam_dma_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ppu_mode(ppu_mode), .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      tag;
  } exp_t;
  exp_t cpu_q[$];
  exp_t ppu_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read results land two cycles after issue: memory latency plus the output register.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      e = cpu_q.pop_front();
      check(e.tag, {8'h00, cpu_rdata}, {8'h00, e.exp});
    end
    if (ppu_q.size() > 0 && ppu_q[0].due == cyc) begin
      e = ppu_q.pop_front();
      check(e.tag, {8'h00, ppu_rdata}, {8'h00, e.exp});
    end
  end

  // Called at posedge+1; drives one cycle of requests and returns at the next posedge+1.
  task automatic drive(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [7:0] wdata, input logic [7:0] cexp,
                       input logic prd, input logic [15:0] paddr, input logic [7:0] pexp,
                       input string tag);
    exp_t e;
    cpu_wr = wr; cpu_rd = rd; cpu_addr = addr; cpu_wdata = wdata;
    ppu_rd = prd; ppu_addr = paddr;
    if (rd) begin e.due = cyc + 2; e.exp = cexp; e.tag = {tag, "_cpu"}; cpu_q.push_back(e); end
    if (prd) begin e.due = cyc + 2; e.exp = pexp; e.tag = {tag, "_ppu"}; ppu_q.push_back(e); end
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; ppu_rd = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input string tag);
    drive(1'b1, 1'b0, a, d, 8'h00, 1'b0, 16'h0000, 8'h00, tag);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string tag);
    drive(1'b0, 1'b1, a, 8'h00, exp, 1'b0, 16'h0000, 8'h00, tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts active cycles from the current one until dma_active drops, bounded.
  task automatic wait_dma(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!dma_active) break;
      n++;
    end
  endtask

  function automatic int oam_errs(input int lo, input int hi, input logic [7:0] key,
                                  input logic use_key, input logic [7:0] fill);
    int errs = 0;
    for (int i = lo; i <= hi; i++) begin
      logic [7:0] want;
      want = use_key ? (i[7:0] ^ key) : fill;
      if (mem[16'hFE00 + i[15:0]] !== want) errs++;
    end
    return errs;
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + i[15:0]] = i[7:0] ^ 8'h5A;
      mem[16'hD000 + i[15:0]] = i[7:0] ^ 8'hA5;
      mem[16'hFE00 + i[15:0]] = 8'h11;
    end
    mem[16'hFF90] = 8'h5C;
    mem[16'h9800] = 8'h66;
    mem[16'hFEA0] = 8'h3C;

    // Reset state
    step(2);
    @(negedge clk);
    check("rst_dma_active", {15'd0, dma_active}, 16'h0000);
    check("rst_cpu_rdata", {8'h00, cpu_rdata}, 16'h00FF);
    check("rst_ppu_rdata", {8'h00, ppu_rdata}, 16'h00FF);
    check("rst_bus", {mem_addr}, 16'h0000);
    check("rst_bus_ctl", {6'd0, mem_rd, mem_wr, mem_wdata}, 16'h0000);
    rst = 1'b0;
    step(1);

    // Full transfer from C000
    cpu_write(16'hFF46, 8'hC0, "trig_c0");
    wait_dma(n);
    check("full_active_cycles", n[15:0], 16'd321);
    check("full_oam", oam_errs(0, 159, 8'h5A, 1'b1, 8'h00), 16'd0);
    step(1);

    // CPU traffic during a transfer: HRAM read in the START cycle is serviced
    cpu_write(16'hFF46, 8'hC0, "trig_c0b");
    cpu_read(16'hFF90, 8'h5C, "hram_in_start");
    cpu_read(16'hC000, 8'hFF, "c000_during_dma");
    cpu_write(16'h8000, 8'h77, "w8000_during_dma");
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b1, 16'h9800, 8'hFF, "ppu_during_dma");
    wait_dma(n);
    check("dma2_remaining", n[15:0], 16'd317);
    check("w8000_dropped", {8'h00, mem[16'h8000]}, 16'h0000);
    step(1);

    // PPU mode blocking
    ppu_mode = 2'd3;
    cpu_write(16'h9000, 8'hAB, "w9000_mode3");
    cpu_read(16'h9000, 8'hFF, "r9000_mode3");
    cpu_read(16'hFE10, 8'hFF, "rfe10_mode3");
    step(2);
    check("w9000_mode3_dropped", {8'h00, mem[16'h9000]}, 16'h0000);
    ppu_mode = 2'd0;
    cpu_write(16'h9000, 8'hAB, "w9000_mode0");
    cpu_read(16'h9000, 8'hAB, "r9000_mode0");
    ppu_mode = 2'd2;
    cpu_read(16'hFE00, 8'hFF, "rfe00_mode2");
    cpu_read(16'hFE9F, 8'hFF, "rfe9f_mode2");
    cpu_read(16'hFEA0, 8'h3C, "rfea0_mode2");
    ppu_mode = 2'd3;
    cpu_read(16'h7FFF, 8'h00, "r7fff_mode3");

    // PPU beats CPU in the same cycle
    ppu_mode = 2'd1;
    drive(1'b0, 1'b1, 16'hC000, 8'h00, 8'hFF, 1'b1, 16'h9800, 8'h66, "ppu_vs_cpu");
    step(3);

    // Restart at idx 40 with D000 as the new source
    cpu_write(16'hFF46, 8'hC0, "trig_c0c");
    step(81);
    cpu_write(16'hFF46, 8'hD0, "trig_d0");
    wait_dma(n);
    check("restart_active_cycles", n[15:0], 16'd321);
    check("restart_oam", oam_errs(0, 159, 8'hA5, 1'b1, 8'h00), 16'd0);
    step(1);

    // Reset while READ of idx 80 is on the bus
    for (int i = 0; i < 160; i++) mem[16'hFE00 + i[15:0]] = 8'h11;
    cpu_write(16'hFF46, 8'hC0, "trig_c0d");
    step(161);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_dma_active", {15'd0, dma_active}, 16'h0000);
    step(4);
    check("rst_mid_oam_done", oam_errs(0, 79, 8'h5A, 1'b1, 8'h00), 16'd0);
    check("rst_mid_oam_untouched", oam_errs(80, 159, 8'h00, 1'b0, 8'h11), 16'd0);
    check("scoreboard_drained", cpu_q.size() + ppu_q.size(), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
